cordic_core: RTL and testbench

- Iterative, one-micro-rotation-per-enable CORDIC engine for 32-bit signed fixed-point x/y and a 32-bit angle accumulator z.
- Supports circular and hyperbolic systems in both rotation and vectoring modes.
- Sits behind the CORDIC controller interface: the controller loads initial x/y/z, steps iterations, reads the results and watches the overflow flag.
- Output gain is not compensated; the controller pre-scales or post-scales as needed.

---
 rtl/cordic_if.sv | 30 +++
 rtl/cordic_core.sv | 135 +++++++++++++
 tb/tb_cordic_core.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_if.sv
// Controller-side bundle for the CORDIC core: initial values and step strobes in, registered state and flags out.
// load and enable are single-cycle level strobes sampled on each rising clk; results are valid while done is high and stay held until the next load.
interface cordic_if #(
    parameter int p_WIDTH = 32
);
    logic                      load;
    logic                      enable;
    logic                      rot_system;
    logic                      control_mode;
    logic signed [p_WIDTH-1:0] x_in;
    logic signed [p_WIDTH-1:0] y_in;
    logic signed [p_WIDTH-1:0] z_in;
    logic signed [p_WIDTH-1:0] x_out;
    logic signed [p_WIDTH-1:0] y_out;
    logic signed [p_WIDTH-1:0] z_out;
    logic [4:0]                iter_idx;
    logic                      done;
    logic                      overflow;
    logic [1:0]                dbg_state;

    modport master (
        output load, enable, rot_system, control_mode, x_in, y_in, z_in,
        input  x_out, y_out, z_out, iter_idx, done, overflow, dbg_state
    );

    modport slave (
        input  load, enable, rot_system, control_mode, x_in, y_in, z_in,
        output x_out, y_out, z_out, iter_idx, done, overflow, dbg_state
    );
endinterface

// File: rtl/cordic_core.sv
// Iterative CORDIC engine: one circular or hyperbolic micro-rotation per enabled cycle,
// rotation or vectoring mode, uncompensated gain, sticky x/y overflow that freezes the state.
module cordic_core #(
    parameter int p_WIDTH      = 32,
    parameter int p_NUM_ITER   = 15,
    parameter int p_HYP_Z_FRAC = 28
) (
    input logic     clk,
    input logic     rst,
    cordic_if.slave bus
);
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_DONE = 2'd1,
        S_OVF  = 2'd2
    } state_t;

    // atanh table is stored in q3.28; other z fraction widths are derived by shifting
    localparam int lp_HYP_SHR = 28 - p_HYP_Z_FRAC;

    localparam logic [31:0] lp_ATAN [0:31] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
    };

    // entry 0 is never addressed: the hyperbolic sequence starts at shift 1
    localparam logic [31:0] lp_ATANH [0:31] = '{
        32'h00000000, 32'h08C9F53D, 32'h04162BBF, 32'h0202B124,
        32'h01005589, 32'h00800AAB, 32'h00400155, 32'h0020002B,
        32'h00100005, 32'h00080001, 32'h00040000, 32'h00020000,
        32'h00010000, 32'h00008000, 32'h00004000, 32'h00002000,
        32'h00001000, 32'h00000800, 32'h00000400, 32'h00000200,
        32'h00000100, 32'h00000080, 32'h00000040, 32'h00000020,
        32'h00000010, 32'h00000008, 32'h00000004, 32'h00000002,
        32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000
    };

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic signed [p_WIDTH-1:0] r_x;
    logic signed [p_WIDTH-1:0] r_y;
    logic signed [p_WIDTH-1:0] r_z;
    logic [5:0]                r_cnt;

    logic [4:0]                w_hyp_idx;
    logic [4:0]                w_shift;
    logic                      w_d_pos;
    logic                      w_x_sub;
    logic signed [p_WIDTH-1:0] w_xs;
    logic signed [p_WIDTH-1:0] w_ys;
    logic [p_WIDTH-1:0]        w_ang;
    logic [p_WIDTH:0]          w_x_ext;
    logic [p_WIDTH:0]          w_y_ext;
    logic signed [p_WIDTH-1:0] w_z_nxt;
    logic                      w_ovf;
    logic                      w_do_step;

    // Hyperbolic shifts 4, 13 and 40 are executed twice, so the index lags the count after each repeat
    always_comb begin
        w_hyp_idx = r_cnt[4:0] + 5'd1;
        if (r_cnt >= 6'd4)  w_hyp_idx = w_hyp_idx - 5'd1;
        if (r_cnt >= 6'd14) w_hyp_idx = w_hyp_idx - 5'd1;
        if (r_cnt >= 6'd42) w_hyp_idx = w_hyp_idx - 5'd1;
    end

    assign w_shift = bus.rot_system ? r_cnt[4:0] : w_hyp_idx;
    assign w_d_pos = bus.control_mode ? ~r_z[p_WIDTH-1] : r_y[p_WIDTH-1];
    assign w_xs    = r_x >>> w_shift;
    assign w_ys    = r_y >>> w_shift;
    assign w_ang   = bus.rot_system ? p_WIDTH'(lp_ATAN[w_shift])
                                    : p_WIDTH'(lp_ATANH[w_shift] >> lp_HYP_SHR);

    // Circular subtracts d*(y>>>i) from x, hyperbolic adds it
    assign w_x_sub = bus.rot_system ? w_d_pos : ~w_d_pos;
    assign w_x_ext = w_x_sub ? ({r_x[p_WIDTH-1], r_x} - {w_ys[p_WIDTH-1], w_ys})
                             : ({r_x[p_WIDTH-1], r_x} + {w_ys[p_WIDTH-1], w_ys});
    assign w_y_ext = w_d_pos ? ({r_y[p_WIDTH-1], r_y} + {w_xs[p_WIDTH-1], w_xs})
                             : ({r_y[p_WIDTH-1], r_y} - {w_xs[p_WIDTH-1], w_xs});
    assign w_z_nxt = w_d_pos ? (r_z - w_ang) : (r_z + w_ang);
    assign w_ovf   = (w_x_ext[p_WIDTH] != w_x_ext[p_WIDTH-1]) ||
                     (w_y_ext[p_WIDTH] != w_y_ext[p_WIDTH-1]);

    always_comb begin
        w_state_nxt = r_state;
        w_do_step   = 1'b0;
        if (bus.load) begin
            w_state_nxt = S_RUN;
        end else if (bus.enable && (r_state == S_RUN)) begin
            if (w_ovf) begin
                w_state_nxt = S_OVF;
            end else begin
                w_do_step = 1'b1;
                if (r_cnt == 6'(p_NUM_ITER - 1)) w_state_nxt = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_cnt <= '0;
        end else if (bus.load) begin
            r_x   <= bus.x_in;
            r_y   <= bus.y_in;
            r_z   <= bus.z_in;
            r_cnt <= '0;
        end else if (w_do_step) begin
            r_x   <= w_x_ext[p_WIDTH-1:0];
            r_y   <= w_y_ext[p_WIDTH-1:0];
            r_z   <= w_z_nxt;
            r_cnt <= r_cnt + 6'd1;
        end
    end

    assign bus.x_out     = r_x;
    assign bus.y_out     = r_y;
    assign bus.z_out     = r_z;
    assign bus.iter_idx  = w_shift;
    assign bus.done      = (r_state == S_DONE);
    assign bus.overflow  = (r_state == S_OVF);
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_cordic_core.sv
// Directed bench for cordic_core: expected results are queued at load time and checked by a
// monitor when done or overflow rises; control priority and shift sequence are checked inline.
module tb_cordic_core;
    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] z;
        logic [31:0]        tol_xy;
        logic [31:0]        tol_z;
        logic               done;
        logic               ovf;
    } res_t;

    // q0.31 / binary-angle constants
    localparam logic signed [31:0] X_K    = 32'sd1304065673;  // 0.6072529
    localparam logic signed [31:0] R2     = 32'sd1518500207;  // 0.7071068 * circular gain product
    localparam logic signed [31:0] Y_0P1  = 32'sd214748365;   // 0.1
    localparam logic signed [31:0] X_VEC  = 32'sd353639050;   // 0.1 * 1.6467602
    localparam logic signed [31:0] Q_0P99 = 32'sd2126008812;  // 0.99
    localparam logic signed [31:0] Z45    = 32'sh20000000;
    localparam logic signed [31:0] ZM45   = -32'sh20000000;
    localparam logic signed [31:0] Z90    = 32'sh40000000;
    // q3.28 constants; the executed shifts 1,2,3,4,4,5..13,13 give a hyperbolic gain of 0.8281595
    localparam logic signed [31:0] H_X0   = 32'sd323501339;   // 1.2051364
    localparam logic signed [31:0] H_HALF = 32'sd134217728;   // 0.5
    localparam logic signed [31:0] H_ONE  = 32'sd268435456;   // 1.0
    localparam logic signed [31:0] H_COSH = 32'sd302103073;   // 1.2051364*0.8281595*cosh(0.5)
    localparam logic signed [31:0] H_SINH = 32'sd139607013;   // 1.2051364*0.8281595*sinh(0.5)
    localparam logic signed [31:0] H_XV   = 32'sd192523815;   // 0.8281595*sqrt(0.75)
    localparam logic signed [31:0] H_ATH  = 32'sd147453245;   // atanh(0.5)
    localparam int TOL_Q31 = 262144;   // 2^-13 in q0.31
    localparam int TOL_ANG = 119305;   // 0.01 deg
    localparam int TOL_HYP = 268435;   // 1e-3 in q3.28

    logic clk;
    logic rst;
    cordic_if #(.p_WIDTH(32)) bus ();

    cordic_core #(
        .p_WIDTH     (32),
        .p_NUM_ITER  (15),
        .p_HYP_Z_FRAC(28)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    res_t  exp_q[$];
    string name_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;
    logic  evt_q  = 1'b0;
    int    hyp_seq [15] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string nm, input longint act, input longint exp, input longint tol);
        longint diff;
        n_vec++;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (tolerance %0d)", nm, act, exp, tol);
        end
    endtask

    task automatic check_result(input string nm, input res_t e);
        chk({nm, ".x"},    longint'($signed(bus.x_out)), longint'($signed(e.x)), longint'(e.tol_xy));
        chk({nm, ".y"},    longint'($signed(bus.y_out)), longint'($signed(e.y)), longint'(e.tol_xy));
        chk({nm, ".z"},    longint'($signed(bus.z_out)), longint'($signed(e.z)), longint'(e.tol_z));
        chk({nm, ".done"}, longint'(bus.done),     longint'(e.done), 0);
        chk({nm, ".ovf"},  longint'(bus.overflow), longint'(e.ovf),  0);
    endtask

    // Monitor: a result is presented when done or overflow rises
    always @(negedge clk) begin
        logic  evt;
        res_t  e;
        string nm;
        evt = bus.done | bus.overflow;
        if (!rst && evt && !evt_q) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_result: got done=%0d ovf=%0d, expected no result", bus.done, bus.overflow);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check_result(nm, e);
            end
        end
        evt_q = evt;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic signed [31:0] x, input logic signed [31:0] y,
                           input logic signed [31:0] z, input logic rot, input logic mode);
        bus.x_in = x;
        bus.y_in = y;
        bus.z_in = z;
        bus.rot_system = rot;
        bus.control_mode = mode;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic do_enable(input int n);
        bus.enable = 1'b1;
        repeat (n) tick();
        bus.enable = 1'b0;
    endtask

    function automatic res_t mk(input logic signed [31:0] x, input logic signed [31:0] y,
                                input logic signed [31:0] z, input int tol_xy, input int tol_z,
                                input logic dn, input logic ov);
        res_t e;
        e.x = x; e.y = y; e.z = z;
        e.tol_xy = tol_xy; e.tol_z = tol_z;
        e.done = dn; e.ovf = ov;
        return e;
    endfunction

    task automatic push(input string nm, input res_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: got %0d results pending, expected 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        res_t e1;
        rst = 1'b1;
        bus.load = 1'b0; bus.enable = 1'b0;
        bus.rot_system = 1'b1; bus.control_mode = 1'b1;
        bus.x_in = '0; bus.y_in = '0; bus.z_in = '0;
        repeat (3) tick();
        chk("rst.x", bus.x_out, 0, 0);
        chk("rst.y", bus.y_out, 0, 0);
        chk("rst.z", bus.z_out, 0, 0);
        chk("rst.idx_circ", bus.iter_idx, 0, 0);
        chk("rst.done", bus.done, 0, 0);
        chk("rst.ovf", bus.overflow, 0, 0);
        bus.rot_system = 1'b0;
        #1;
        chk("rst.idx_hyp", bus.iter_idx, 1, 0);
        rst = 1'b0;
        tick();

        // circular rotation by +45 deg
        e1 = mk(R2, R2, 0, TOL_Q31, TOL_ANG, 1'b1, 1'b0);
        do_load(X_K, 0, Z45, 1'b1, 1'b1);
        push("circ_rot", e1);
        do_enable(14);
        chk("circ_rot.done_at_14", bus.done, 0, 0);
        do_enable(1);
        drain();
        do_enable(2);
        check_result("circ_rot_hold", e1);
        chk("circ_rot_hold.idx", bus.iter_idx, 15, 0);

        // circular vectoring from the +y axis
        do_load(0, Y_0P1, 0, 1'b1, 1'b0);
        push("circ_vec", mk(X_VEC, 0, Z90, TOL_Q31, TOL_ANG, 1'b1, 1'b0));
        do_enable(15);
        drain();

        // hyperbolic rotation by 0.5
        do_load(H_X0, 0, H_HALF, 1'b0, 1'b1);
        push("hyp_rot", mk(H_COSH, H_SINH, 0, TOL_HYP, TOL_HYP, 1'b1, 1'b0));
        do_enable(15);
        drain();

        // hyperbolic vectoring, shift index walked step by step
        do_load(H_ONE, H_HALF, 0, 1'b0, 1'b0);
        push("hyp_vec", mk(H_XV, 0, H_ATH, TOL_HYP, TOL_HYP, 1'b1, 1'b0));
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("hyp_vec.idx%0d", k), bus.iter_idx, hyp_seq[k], 0);
            do_enable(1);
        end
        drain();

        // overflow on the first micro-rotation: state holds the loaded values
        e1 = mk(Q_0P99, Q_0P99, Z45, 0, 0, 1'b0, 1'b1);
        do_load(Q_0P99, Q_0P99, Z45, 1'b1, 1'b1);
        push("ovf", e1);
        do_enable(1);
        drain();
        do_enable(3);
        check_result("ovf_hold", e1);
        chk("ovf_hold.idx", bus.iter_idx, 0, 0);
        do_load(X_K, 0, Z45, 1'b1, 1'b1);
        chk("ovf_clear.ovf", bus.overflow, 0, 0);
        chk("ovf_clear.x", bus.x_out, X_K, 0);

        // reset in the middle of a run, with enable also high
        do_enable(5);
        rst = 1'b1;
        bus.enable = 1'b1;
        tick();
        chk("mid_rst.x", bus.x_out, 0, 0);
        chk("mid_rst.y", bus.y_out, 0, 0);
        chk("mid_rst.z", bus.z_out, 0, 0);
        chk("mid_rst.idx", bus.iter_idx, 0, 0);
        chk("mid_rst.done", bus.done, 0, 0);
        rst = 1'b0;
        bus.enable = 1'b0;
        tick();

        // load coinciding with enable: load wins and the count restarts
        do_load(X_K, 0, Z45, 1'b1, 1'b1);
        do_enable(3);
        bus.enable = 1'b1;
        do_load(X_K, 0, ZM45, 1'b1, 1'b1);
        bus.enable = 1'b0;
        chk("load_en.x", bus.x_out, X_K, 0);
        chk("load_en.y", bus.y_out, 0, 0);
        chk("load_en.z", bus.z_out, ZM45, 0);
        chk("load_en.idx", bus.iter_idx, 0, 0);
        push("circ_rot_neg", mk(R2, -R2, 0, TOL_Q31, TOL_ANG, 1'b1, 1'b0));
        do_enable(15);
        drain();

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        n_vec++;
        n_miss++;
        $display("FAIL watchdog: got simulation still running, expected finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "watchdog expired");
    end
endmodule
